serializer: RTL and testbench



---
 rtl/serializer.sv | 71 +++++++
 tb/tb_serializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a word plus bit count and shifts the
// top L bits out MSB-first, one per clock, with a valid strobe and busy flag.
module serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int MOD_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]  data_mod_i,
  input  logic                  data_val_i,
  output logic                  ser_data_o,
  output logic                  ser_data_val_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  // Bits still to emit after the one currently on ser_data_o.
  logic [MOD_WIDTH:0]    bit_cnt;
  logic [MOD_WIDTH:0]    eff_len;
  logic                  accept;

  // A length field of zero encodes a full word.
  assign eff_len = (data_mod_i == '0) ? (MOD_WIDTH+1)'(DATA_WIDTH)
                                      : {1'b0, data_mod_i};
  assign accept  = (state == IDLE) && data_val_i && (eff_len >= 3);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= SEND;
            ser_data_o     <= data_i[DATA_WIDTH-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
            shift_reg      <= data_i << 1;
            bit_cnt        <= eff_len - 1'b1;
          end
        end
        SEND: begin
          if (bit_cnt == '0) begin
            state          <= IDLE;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
            shift_reg      <= '0;
          end else begin
            ser_data_o     <= shift_reg[DATA_WIDTH-1];
            shift_reg      <= shift_reg << 1;
            bit_cnt        <= bit_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed vector table, hand-written
// corner sequences and random traffic against a bit-queue reference model.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  // Reference model: the bits still owed on the line, front = current bit.
  bit model_q[$];

  int          rx_cnt;
  logic [31:0] rx_word;
  int          model_accepts;
  int          model_bits_total;
  int          rx_bits_total;

  serializer #(.DATA_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare outputs.
  task automatic tick(input logic val, input logic [15:0] d, input logic [3:0] m, input logic rst);
    int len;
    bit exp_val;
    bit exp_bit;
    data_val_i = val;
    data_i     = d;
    data_mod_i = m;
    srst_i     = rst;
    @(posedge clk_i);
    if (rst) begin
      model_q.delete();
    end else if (model_q.size() == 0) begin
      len = (m == 0) ? 16 : int'(m);
      if (val && len >= 3) begin
        model_accepts++;
        model_bits_total += len;
        for (int k = 0; k < len; k++) model_q.push_back(d[15-k]);
      end
    end else begin
      void'(model_q.pop_front());
    end
    #1;
    exp_val = (model_q.size() > 0);
    exp_bit = exp_val ? model_q[0] : 1'b0;
    check("ser_data_val_o", {31'd0, ser_data_val_o}, {31'd0, exp_val});
    check("busy_o",         {31'd0, busy_o},         {31'd0, exp_val});
    check("ser_data_o",     {31'd0, ser_data_o},     {31'd0, exp_bit});
    if (ser_data_val_o === 1'b1) begin
      rx_word = {rx_word[30:0], ser_data_o};
      rx_cnt++;
      rx_bits_total++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          exp_cnt;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    srst_i = 1'b1; data_val_i = 1'b0; data_i = '0; data_mod_i = '0;
    rx_cnt = 0; rx_word = '0; model_accepts = 0; model_bits_total = 0; rx_bits_total = 0;

    // Reset state, with a request presented during reset (reset wins).
    tick(1'b1, 16'hFFFF, 4'd0, 1'b1);
    tick(1'b0, 16'h0000, 4'd0, 1'b1);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    idle(2);

    vecs[0] = '{16'hA5C3, 4'd0, 16, 32'h0000_A5C3};
    vecs[1] = '{16'hB000, 4'd4,  4, 32'h0000_000B};
    vecs[2] = '{16'hFFFF, 4'd1,  0, 32'h0000_0000};
    vecs[3] = '{16'hFFFF, 4'd2,  0, 32'h0000_0000};
    vecs[4] = '{16'hE000, 4'd3,  3, 32'h0000_0007};
    vecs[5] = '{16'h6FFF, 4'd3,  3, 32'h0000_0003};
    vecs[6] = '{16'h8001, 4'd15, 15, 32'h0000_4000};

    for (int v = 0; v < 7; v++) begin
      rx_cnt = 0; rx_word = '0;
      tick(1'b1, vecs[v].data, vecs[v].mod, 1'b0);
      idle(20);
      check($sformatf("vec%0d_count", v), rx_cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_bits", v),  rx_word, vecs[v].exp_word);
    end

    // Busy rejection: requests held high throughout are ignored until idle.
    rx_cnt = 0; rx_word = '0;
    tick(1'b1, 16'hFF00, 4'd8, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b1, 16'h0000, 4'd8, 1'b0);
    check("busy_rej_count", rx_cnt, 8);
    check("busy_rej_bits", rx_word, 32'h0000_00FF);
    tick(1'b1, 16'h0000, 4'd8, 1'b0);
    check("busy_rej_gap_busy", {31'd0, busy_o}, 32'd0);
    check("busy_rej_gap_val", {31'd0, ser_data_val_o}, 32'd0);
    tick(1'b1, 16'hC000, 4'd3, 1'b0);
    check("busy_rej_next_val", {31'd0, ser_data_val_o}, 32'd1);
    check("busy_rej_next_bit", {31'd0, ser_data_o}, 32'd1);
    idle(10);

    // Reset during bit 5 of a full-word packet aborts it for good.
    rx_cnt = 0; rx_word = '0;
    tick(1'b1, 16'hFFFF, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'hFFFF, 4'd0, 1'b0);
    tick(1'b0, 16'hFFFF, 4'd0, 1'b1);
    check("rst_mid_val", {31'd0, ser_data_val_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_bit", {31'd0, ser_data_o}, 32'd0);
    idle(20);
    check("rst_mid_count", rx_cnt, 6);
    rx_cnt = 0; rx_word = '0;
    tick(1'b1, 16'hE000, 4'd3, 1'b0);
    idle(6);
    check("rst_after_count", rx_cnt, 3);
    check("rst_after_bits", rx_word, 32'h0000_0007);

    // Random traffic: 1000 requests with random timing and rare resets.
    for (int r = 0; r < 1000; r++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) tick(1'b0, 16'h0, 4'h0, 1'b1);
      tick(1'b1, 16'($urandom), 4'($urandom), 1'b0);
      for (int c = 0; c < 40 && model_q.size() > 0; c++)
        tick($urandom_range(0, 1) == 1, 16'($urandom), 4'($urandom), 1'b0);
    end
    idle(20);
    check("model_queue_drained", model_q.size(), 0);
    check("final_busy", {31'd0, busy_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
